// File: rtl/unit_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unit_fifo_pkg
//  Description : Shared widths, word/record types and transmit FSM encoding
//                for the per-unit result FIFO and serial transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package unit_fifo_pkg;

    localparam int DATA_W        = 20;
    localparam int META_W        = 16;
    localparam int WORD_W        = 36;
    localparam int WORDS_PER_REC = 5;
    localparam int REC_BITS      = 180;
    localparam int HOLD_BITS     = WORD_W * (WORDS_PER_REC - 1);
    localparam int BIT_CNT_W     = 8;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(REC_BITS - 1);

    typedef struct packed {
        logic [META_W-1:0] meta;
        logic [DATA_W-1:0] data;
    } unit_word_t;

    typedef logic [REC_BITS-1:0] unit_rec_t;

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // Build a result word from its two input fields.
    function automatic unit_word_t pack_word(input logic [META_W-1:0] meta,
                                             input logic [DATA_W-1:0] data);
        unit_word_t w;
        w.meta = meta;
        w.data = data;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unit_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : unit_fifo_ram
//  Description : DEPTH x 180-bit record storage with wrapping read/write
//                pointers and an occupancy counter. The head record is read
//                combinationally so a pop and a shift-register load coincide.
//  Revision    : 1.0 - initial release
// ============================================================================
module unit_fifo_ram
    import unit_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  unit_rec_t                  wdata,
    output unit_rec_t                  rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    unit_rec_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Record storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/unit_fifo_tx.sv
`default_nettype none
// ============================================================================
//  Module      : unit_fifo_tx
//  Description : Assembles five 36-bit result words into 180-bit records,
//                buffers them and shifts one record out LSB-first per
//                fifo_req pulse. An idle instance drives fifo_bits low so the
//                controller can OR all instances together.
//  Config      : UNIT_FIFO_OFLOW_STICKY_EN - overflow flag held until reset
//                (otherwise cleared when a real record burst completes).
//  Revision    : 1.0 - initial release
// ============================================================================
module unit_fifo_tx
    import unit_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [META_W-1:0]   in_meta,
    input  logic                in_valid,
    input  logic                fifo_req,
    output logic                fifo_bits,
    output logic                fifo_empty,
    output logic                fifo_oflow
);

    logic [2:0]             r_word_cnt;
    logic [HOLD_BITS-1:0]   r_hold;
    unit_word_t             w_word;
    unit_rec_t              w_rec;
    logic                   w_rec_done;
    logic                   w_push;
    logic                   w_drop;

    unit_rec_t              w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_empty;
    logic                   w_full;

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic                   w_load;
    logic                   w_pop;
    logic                   w_burst_done;
    unit_rec_t              r_shreg;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_real;
    logic                   r_bits;
    logic                   r_oflow;

    assign w_word     = pack_word(in_meta, in_data);
    assign w_rec_done = in_valid && (r_word_cnt == 3'(WORDS_PER_REC - 1));
    assign w_rec      = {w_word, r_hold};
    // The pop frees a slot first, so a completion at full is kept if a pop coincides.
    assign w_push     = w_rec_done && (!w_full || w_pop);
    assign w_drop     = w_rec_done && w_full && !w_pop;

    unit_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_rec),
        .rdata (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // Word assembler: slot the first four words into the holding register, the fifth completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_cnt <= '0;
            r_hold     <= '0;
        end else if (in_valid) begin
            if (w_rec_done) begin
                r_word_cnt <= '0;
            end else begin
                for (int i = 0; i < WORDS_PER_REC - 1; i++) begin
                    if (r_word_cnt == 3'(i)) r_hold[i*WORD_W +: WORD_W] <= w_word;
                end
                r_word_cnt <= r_word_cnt + 3'd1;
            end
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= TX_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Transmit FSM next state; requests during a burst are dropped silently.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (fifo_req) begin
                    w_load      = 1'b1;
                    w_pop       = !w_empty;
                    w_state_nxt = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (r_bit_cnt == LAST_BIT) w_state_nxt = TX_IDLE;
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    assign w_burst_done = (r_state == TX_SHIFT) && (r_bit_cnt == LAST_BIT);

    // Shift datapath: load the head (or zeros when empty), then emit one bit per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_real    <= 1'b0;
            r_bits    <= 1'b0;
        end else if (w_load) begin
            r_shreg   <= w_pop ? w_head : '0;
            r_bit_cnt <= '0;
            r_real    <= w_pop;
            r_bits    <= 1'b0;
        end else if (r_state == TX_SHIFT) begin
            r_bits    <= r_shreg[0];
            r_shreg   <= {1'b0, r_shreg[REC_BITS-1:1]};
            r_bit_cnt <= w_burst_done ? '0 : r_bit_cnt + 1'b1;
        end else begin
            r_bits    <= 1'b0;
        end
    end

    // Overflow flag: a drop always sets it; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oflow <= 1'b0;
        end else if (w_drop) begin
            r_oflow <= 1'b1;
        end
`ifdef UNIT_FIFO_OFLOW_STICKY_EN
`else
        else if (w_burst_done && r_real) begin
            r_oflow <= 1'b0;
        end
`endif
    end

    assign fifo_bits  = r_bits;
    assign fifo_empty = w_empty;
    assign fifo_oflow = r_oflow;

endmodule
`default_nettype wire

// File: tb/tb_unit_fifo_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unit_fifo_tx
//  Description : Self-checking bench for unit_fifo_tx. A queue-based model
//                predicts fifo_bits / fifo_empty / fifo_oflow each cycle;
//                directed scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unit_fifo_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] in_data = '0;
    logic [15:0] in_meta = '0;
    logic        in_valid = 1'b0;
    logic        fifo_req = 1'b0;
    logic        fifo_bits;
    logic        fifo_empty;
    logic        fifo_oflow;

    int n_checks = 0;
    int n_fail   = 0;

    unit_fifo_tx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_meta    (in_meta),
        .in_valid   (in_valid),
        .fifo_req   (fifo_req),
        .fifo_bits  (fifo_bits),
        .fifo_empty (fifo_empty),
        .fifo_oflow (fifo_oflow)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: queue of whole records, cycle-stamped bursts.
    // ------------------------------------------------------------------
    logic [179:0] mq[$];
    logic [143:0] m_hold = '0;
    int           m_n = 0;
    bit           m_oflow = 0;
    longint       m_cyc = 0;
    longint       m_t0 = -1000;
    bit           m_real = 0;
    logic [179:0] m_rec = '0;
    logic         exp_bits = 1'b0;
    logic         exp_empty = 1'b1;
    logic         exp_oflow = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_hold = '0; m_n = 0; m_oflow = 0; m_cyc = 0; m_t0 = -1000;
            m_real = 0; m_rec = '0;
            exp_bits = 1'b0; exp_empty = 1'b1; exp_oflow = 1'b0;
        end else begin
            bit     drop;
            bit     clr;
            longint k;
            drop = 0;
            clr  = m_real && (m_cyc == m_t0 + 180);
            if (fifo_req && (m_cyc >= m_t0 + 181)) begin
                m_t0 = m_cyc;
                if (mq.size() > 0) begin m_rec = mq.pop_front(); m_real = 1; end
                else               begin m_rec = '0;             m_real = 0; end
            end
            if (in_valid) begin
                if (m_n == 4) begin
                    if (mq.size() >= DEPTH) drop = 1;
                    else mq.push_back({in_meta, in_data, m_hold});
                    m_n = 0;
                end else begin
                    m_hold[m_n*36 +: 36] = {in_meta, in_data};
                    m_n++;
                end
            end
            if (drop) m_oflow = 1;
`ifndef UNIT_FIFO_OFLOW_STICKY_EN
            else if (clr) m_oflow = 0;
`endif
            k = m_cyc - 1 - m_t0;
            exp_bits  = (k >= 0 && k < 180) ? m_rec[int'(k)] : 1'b0;
            exp_empty = (mq.size() == 0);
            exp_oflow = m_oflow;
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("fifo_bits",  {63'd0, fifo_bits},  {63'd0, exp_bits});
        check("fifo_empty", {63'd0, fifo_empty}, {63'd0, exp_empty});
        check("fifo_oflow", {63'd0, fifo_oflow}, {63'd0, exp_oflow});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge).
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [19:0] d, input logic [15:0] m, input logic r);
        @(negedge clk);
        in_valid = v; in_data = d; in_meta = m; fifo_req = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 20'd0, 16'd0, 1'b0);
    endtask

    // Record with first data value base: word j = {A000+base+j, base+j}.
    task automatic push_rec(input int base);
        for (int j = 0; j < 5; j++)
            drive(1'b1, 20'(base + j), 16'(16'hA000 + base + j), 1'b0);
    endtask

    // Pulse fifo_req in cycle t, report fifo_empty at t+1, capture bits t+2..t+181.
    task automatic read_burst(output logic [179:0] rec, output logic e1);
        drive(1'b0, 20'd0, 16'd0, 1'b1);
        drive(1'b0, 20'd0, 16'd0, 1'b0);
        e1 = fifo_empty;
        for (int k = 0; k < 180; k++) begin
            @(negedge clk);
            rec[k] = fifo_bits;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk); #2 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [179:0] rec;
        logic         e1;
        int           bases[4];

        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_bits",  {63'd0, fifo_bits},  64'd0);
        check("reset_empty", {63'd0, fifo_empty}, 64'd1);
        check("reset_oflow", {63'd0, fifo_oflow}, 64'd0);

        // Single record round trip.
        push_rec(1);
        idle(1);
        check("empty_after_push", {63'd0, fifo_empty}, 64'd0);
        read_burst(rec, e1);
        check("empty_t1_after_pop", {63'd0, e1}, 64'd1);
        check("rec0_word0", {28'd0, rec[35:0]},  {28'd0, 16'hA001, 20'h00001});
        check("rec0_word1", {28'd0, rec[71:36]}, {28'd0, 16'hA002, 20'h00002});
        check("rec0_word4", {28'd0, rec[179:144]}, {28'd0, 16'hA005, 20'h00005});
        idle(3);

        // Request while empty produces a zero burst.
        read_burst(rec, e1);
        check("zero_burst_lo", rec[63:0], 64'd0);
        check("zero_burst_hi", {12'd0, rec[179:128]}, 64'd0);
        check("zero_burst_empty", {63'd0, e1}, 64'd1);
        idle(3);

        // Overflow: DEPTH+1 records with no reads, the last is dropped.
        for (int i = 0; i <= DEPTH; i++) push_rec(5 * i + 1);
        idle(1);
        check("oflow_set", {63'd0, fifo_oflow}, 64'd1);
        bases = '{1, 6, 11, 16};
        for (int i = 0; i < DEPTH; i++) begin
            read_burst(rec, e1);
            check("oflow_rec_word0", {44'd0, rec[19:0]}, {44'd0, 20'(bases[i])});
`ifdef UNIT_FIFO_OFLOW_STICKY_EN
            check("oflow_after_burst", {63'd0, fifo_oflow}, 64'd1);
`else
            check("oflow_after_burst", {63'd0, fifo_oflow}, 64'd0);
`endif
        end
        idle(1);
        check("empty_after_drain", {63'd0, fifo_empty}, 64'd1);

        // Second request mid-burst is ignored.
        do_reset();
        push_rec(1);
        push_rec(6);
        drive(1'b0, 20'd0, 16'd0, 1'b1);
        idle(49);
        drive(1'b0, 20'd0, 16'd0, 1'b1);
        idle(140);
        check("one_left_after_ignored_req", {63'd0, fifo_empty}, 64'd0);
        read_burst(rec, e1);
        check("second_rec_word0", {44'd0, rec[19:0]}, 64'd6);
        check("empty_after_second", {63'd0, e1}, 64'd1);

        // Completion at full coinciding with a pop is accepted and read last.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_rec(5 * i + 1);
        for (int j = 0; j < 4; j++) drive(1'b1, 20'(101 + j), 16'(16'hB000 + j), 1'b0);
        drive(1'b1, 20'd105, 16'hB004, 1'b1);
        drive(1'b0, 20'd0, 16'd0, 1'b0);
        check("full_pop_no_oflow", {63'd0, fifo_oflow}, 64'd0);
        check("full_pop_not_empty", {63'd0, fifo_empty}, 64'd0);
        for (int k = 0; k < 180; k++) begin
            @(negedge clk);
            rec[k] = fifo_bits;
        end
        check("full_pop_first_word0", {44'd0, rec[19:0]}, 64'd1);
        bases = '{6, 11, 16, 101};
        for (int i = 0; i < DEPTH; i++) begin
            read_burst(rec, e1);
            check("full_pop_order_word0", {44'd0, rec[19:0]}, {44'd0, 20'(bases[i])});
        end
        check("full_pop_last_meta", {48'd0, rec[179:164]}, {48'd0, 16'hB004});
        idle(1);
        check("full_pop_drained", {63'd0, fifo_empty}, 64'd1);

        // Reset asserted mid-burst.
        push_rec(1);
        push_rec(6);
        drive(1'b0, 20'd0, 16'd0, 1'b1);
        idle(90);
        #2 reset = 1'b1;
        #1;
        check("midreset_bits",  {63'd0, fifo_bits},  64'd0);
        check("midreset_empty", {63'd0, fifo_empty}, 64'd1);
        check("midreset_oflow", {63'd0, fifo_oflow}, 64'd0);
        @(negedge clk);
        @(negedge clk); #2 reset = 1'b0;
        read_burst(rec, e1);
        check("post_reset_zero_lo", rec[63:0], 64'd0);
        check("post_reset_zero_hi", {12'd0, rec[179:128]}, 64'd0);
        check("post_reset_empty", {63'd0, e1}, 64'd1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
